// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin arbiter slice: index-width helpers,
// the grant queue state encoding and the default requester count.
package rr_arb_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // A single requester still needs a one-bit index.
  function automatic int idx_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/grant_encoder_if.sv
// Grant-in / index-out channel of grant_encoder; the master side drives the
// grant and the ack, the slave side is the encoder.
interface grant_encoder_if
  import rr_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  localparam int IDXW = idx_width(WIDTH);

  logic [WIDTH-1:0] grant_in;
  logic             grant_valid;
  logic             grant_ready;
  logic [IDXW-1:0]  idx_out;
  logic             idx_valid;
  logic             idx_ack;
  logic [1:0]       occupancy;
  logic             onehot_err;

  modport master (
    output grant_in, grant_valid, idx_ack,
    input  grant_ready, idx_out, idx_valid, occupancy, onehot_err
  );

  modport slave (
    input  grant_in, grant_valid, idx_ack,
    output grant_ready, idx_out, idx_valid, occupancy, onehot_err
  );
endinterface

// File: rtl/onehot_to_bin.sv
// Priority encoder: the lowest set bit of vec wins; multi_hot flags a vector
// with more than one bit set.
module onehot_to_bin
  import rr_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDXW  = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDXW-1:0]  idx,
  output logic             multi_hot
);

  always_comb begin
    // NOTE: default assignment first so no path through the loop infers a latch.
    idx = '0;
    // Scanning downward lets the lowest set bit overwrite any higher one.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDXW'(i);
    end
  end

  assign multi_hot = (vec & (vec - WIDTH'(1))) != '0;

endmodule

// File: rtl/grant_encoder.sv
// One-hot grant to binary index encoder with a 2-entry skid queue.
// Optional multi-hot detection is enabled by defining GRANT_ENCODER_ONEHOT_CHECK_EN.
module grant_encoder
  import rr_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic            clock,
  input logic            reset,
  grant_encoder_if.slave bus
);

  localparam int IDXW = idx_width(WIDTH);

  state_t          state;
  logic [IDXW-1:0] head;
  logic [IDXW-1:0] tail;
  logic            valid_q;
  logic            ready_q;
  logic [1:0]      occ_q;

  logic [IDXW-1:0] enc_idx;
  logic            multi_hot;
  logic            push;
  logic            pop;

  onehot_to_bin #(
    .WIDTH (WIDTH),
    .IDXW  (IDXW)
  ) u_enc (
    .vec       (bus.grant_in),
    .idx       (enc_idx),
    .multi_hot (multi_hot)
  );

  // A zero grant is accepted but stores nothing, so it never counts as a push.
  assign push = bus.grant_valid & ready_q & (bus.grant_in != '0);
  assign pop  = bus.idx_ack & valid_q;

  // All outputs are registered alongside the state so none depends on idx_ack.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= EMPTY;
      head    <= '0;
      tail    <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      occ_q   <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        EMPTY: begin
          if (push) begin
            head    <= enc_idx;
            valid_q <= 1'b1;
            occ_q   <= 2'd1;
            state   <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head <= enc_idx;
          end else if (push) begin
            tail    <= enc_idx;
            ready_q <= 1'b0;
            occ_q   <= 2'd2;
            state   <= FULL;
          end else if (pop) begin
            valid_q <= 1'b0;
            occ_q   <= 2'd0;
            state   <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head    <= tail;
            ready_q <= 1'b1;
            occ_q   <= 2'd1;
            state   <= ONE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          occ_q   <= 2'd0;
          state   <= EMPTY;
        end
      endcase
    end
  end

  assign bus.idx_out     = head;
  assign bus.idx_valid   = valid_q;
  assign bus.grant_ready = ready_q;
  assign bus.occupancy   = occ_q;

`ifdef GRANT_ENCODER_ONEHOT_CHECK_EN
  logic err_q;

  // Sticky until reset; the offending entry is still queued as its lowest bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (push && multi_hot) begin
      err_q <= 1'b1;
    end
  end

  assign bus.onehot_err = err_q;
`else
  logic unused_multi_hot;

  assign unused_multi_hot = multi_hot;
  assign bus.onehot_err   = 1'b0;
`endif

endmodule

// File: doc/grant_encoder.md
Name: grant_encoder

Overview:
- Encodes the one-hot grant vector from the round-robin arbiter core into a binary requester index.
- The encoded index is buffered in a 2-entry skid queue and delivered to the consumer through a valid/ack handshake.
- It is the counterpart of the index-to-one-hot decode register on the consumer side, and sits between the arbiter grant output and the downstream channel-select logic.

Parameters:
- WIDTH, 4, number of requesters; width of the one-hot grant vector.
- IDXW, clog2(WIDTH) with a minimum of 1, width of the encoded index.

Ports:
- clock  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- grant_in  input  WIDTH  one-hot grant from the arbiter.
- grant_valid  input  1  grant_in is meaningful this cycle.
- grant_ready  output  1  encoder can accept a grant this cycle.
- idx_out  output  IDXW  encoded index at the queue head.
- idx_valid  output  1  idx_out holds a pending index.
- idx_ack  input  1  consumer takes the head entry.
- occupancy  output  2  number of entries held, 0..2.
- onehot_err  output  1  sticky flag, set on a multi-hot grant (feature only; tied 0 otherwise).

Behaviour:
- Reset: all state is cleared asynchronously on the negedge of reset. idx_out=0, idx_valid=0, occupancy=0, grant_ready=1, onehot_err=0, state=EMPTY.
- Push: occurs when grant_valid & grant_ready & (grant_in != 0). The stored index is the lowest set bit of grant_in.
- Zero grant: grant_valid with grant_in==0 is accepted as a no-op. Nothing is stored and the state does not change.
- Pop: occurs when idx_ack & idx_valid. idx_ack while idx_valid=0 is ignored.
- Latency: a grant pushed in cycle N appears on idx_out with idx_valid=1 in cycle N+1 when the queue was EMPTY. idx_out is registered, with no combinational path from grant_in to idx_out.
- States:
  - EMPTY: idx_valid=0, grant_ready=1.
  - ONE: idx_valid=1, grant_ready=1.
  - FULL: idx_valid=1, grant_ready=0.
- Transitions:
  - EMPTY + push -> ONE.
  - ONE + push without pop -> FULL.
  - ONE + pop without push -> EMPTY.
  - ONE + push + pop -> ONE; the new index becomes the head in the next cycle.
  - FULL + pop -> ONE; the second entry moves to the head.
  - FULL never pushes, because grant_ready=0.
- Outputs are functions of registered state only. grant_ready does not depend combinationally on idx_ack.
- Ordering: entries leave in strict FIFO order. No entry is duplicated or dropped except on reset.
- Reset mid-transfer: pending entries are discarded. The consumer must treat reset as abort.
- WIDTH=1: IDXW=1 and idx_out is always 0.
- Without the feature, a multi-hot grant still encodes the lowest set bit and raises no flag.

Optional Feature:
- Macro: GRANT_ENCODER_ONEHOT_CHECK_EN.
- When defined:
  - A push with more than one bit set in grant_in sets onehot_err on the next clock edge.
  - onehot_err stays set until reset.
  - The entry is still stored, encoded as the lowest set bit.
  - A zero grant does not set the flag.
- When undefined: onehot_err is tied to 0 and no check logic is generated.

Decomposition:
- Shared package rr_arb_pkg holds:
  - the clog2 constant function;
  - the state encodings (EMPTY=2'd0, ONE=2'd1, FULL=2'd2);
  - the default WIDTH.
- One natural sub-module, onehot_to_bin. It is a combinational priority encoder (lowest set bit wins) with a multi_hot output, used by the push path.

Test Plan:
- Reset then single grant: reset low for 3 cycles, then grant_in=4'b0100 with valid for 1 cycle. Expect idx_out=2, idx_valid=1 in the next cycle and occupancy=1. ack=1 then gives idx_valid=0 and occupancy=0.
- Fill/backpressure: push 4'b0001, then 4'b1000, with ack=0. Expect occupancy=2 and grant_ready=0. A third push of 4'b0010 is not accepted. Ack twice; expect idx_out 0 then 3.
- Simultaneous push+pop in ONE: head=1 (from 4'b0010). Push 4'b1000 with ack=1 in the same cycle. Expect occupancy to stay 1 and idx_out=3 in the next cycle.
- Zero grant: grant_valid=1, grant_in=0 while EMPTY. Expect grant_ready=1, idx_valid to stay 0, occupancy=0.
- Reset mid-operation: with occupancy=2, pulse reset low between clock edges. Expect an immediate asynchronous clear: idx_valid=0, occupancy=0, grant_ready=1.
- Feature check (macro defined): push 4'b0110. Expect idx_out=1 and onehot_err=1 in the next cycle. The flag stays 1 after a later push of 4'b0001 and clears only on reset. With the macro undefined, onehot_err stays 0.
